// File: rtl/lcd_bus_receiver.sv
// Display-side responder for an 8080-style write bus: decodes CASET/PASET/RAMWR/SWRESET/DISPON/DISPOFF,
// tracks the address window and write cursor, and emits one strobe per RGB565 pixel.
module lcd_bus_receiver #(
  parameter int H_RES = 320,
  parameter int V_RES = 240
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        wr,
  input  logic        dcx,
  input  logic [7:0]  D,
  output logic        pix_valid,
  output logic [15:0] pix_x,
  output logic [15:0] pix_y,
  output logic [15:0] pix_color,
  output logic        frame_done,
  output logic        disp_on,
  output logic [7:0]  last_cmd,
  output logic        stray_data
);

  localparam logic [15:0] H_LIM  = 16'(H_RES);
  localparam logic [15:0] V_LIM  = 16'(V_RES);
  localparam logic [15:0] EC_RST = 16'(H_RES - 1);
  localparam logic [15:0] EP_RST = 16'(V_RES - 1);

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_DISPOFF = 8'h28;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CAS0, S_CAS1, S_CAS2, S_CAS3,
    S_PAS0, S_PAS1, S_PAS2, S_PAS3,
    S_PIX_HI, S_PIX_LO
  } state_t;

  // An inverted window collapses to a single line starting at the start address.
  function automatic logic [15:0] clamp_end(input logic [15:0] s, input logic [15:0] e);
    return (s > e) ? s : e;
  endfunction

  state_t      state_q, state_d;
  logic        wr_q;
  logic        ev, cmd_ev;
  logic [15:0] sc, ec, sp, ep;
  logic [15:0] cx, cy;
  logic [7:0]  sh_s_hi, sh_s_lo, sh_e_hi, hi_byte;
  logic [15:0] commit_s, commit_e;

  logic do_sh0, do_sh1, do_sh2, do_cas_commit, do_pas_commit;
  logic do_hi, do_pix, do_stray;
  logic do_swreset, do_dispon, do_dispoff, do_ramwr;

  assign ev       = wr & ~wr_q;
  assign cmd_ev   = ev & ~dcx;
  assign commit_s = {sh_s_hi, sh_s_lo};
  assign commit_e = clamp_end(commit_s, {sh_e_hi, D});

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (ev) begin
      if (!dcx) begin
        case (D)
          CMD_CASET: state_d = S_CAS0;
          CMD_PASET: state_d = S_PAS0;
          CMD_RAMWR: state_d = S_PIX_HI;
          default:   state_d = S_IDLE;
        endcase
      end else begin
        case (state_q)
          S_CAS0:   state_d = S_CAS1;
          S_CAS1:   state_d = S_CAS2;
          S_CAS2:   state_d = S_CAS3;
          S_CAS3:   state_d = S_IDLE;
          S_PAS0:   state_d = S_PAS1;
          S_PAS1:   state_d = S_PAS2;
          S_PAS2:   state_d = S_PAS3;
          S_PAS3:   state_d = S_IDLE;
          S_PIX_HI: state_d = S_PIX_LO;
          S_PIX_LO: state_d = S_PIX_HI;
          default:  state_d = S_IDLE;
        endcase
      end
    end
  end

  // Action decode
  always_comb begin
    do_sh0        = 1'b0;
    do_sh1        = 1'b0;
    do_sh2        = 1'b0;
    do_cas_commit = 1'b0;
    do_pas_commit = 1'b0;
    do_hi         = 1'b0;
    do_pix        = 1'b0;
    do_stray      = 1'b0;
    do_swreset    = 1'b0;
    do_dispon     = 1'b0;
    do_dispoff    = 1'b0;
    do_ramwr      = 1'b0;
    if (cmd_ev) begin
      do_swreset = (D == CMD_SWRESET);
      do_dispon  = (D == CMD_DISPON);
      do_dispoff = (D == CMD_DISPOFF);
      do_ramwr   = (D == CMD_RAMWR);
    end else if (ev) begin
      case (state_q)
        S_CAS0, S_PAS0: do_sh0        = 1'b1;
        S_CAS1, S_PAS1: do_sh1        = 1'b1;
        S_CAS2, S_PAS2: do_sh2        = 1'b1;
        S_CAS3:         do_cas_commit = 1'b1;
        S_PAS3:         do_pas_commit = 1'b1;
        S_PIX_HI:       do_hi         = 1'b1;
        S_PIX_LO:       do_pix        = 1'b1;
        default:        do_stray      = 1'b1;
      endcase
    end
  end

  // Parameter shadows and the pending high byte need no reset: they are always written before use.
  always_ff @(posedge clk) begin
    if (do_sh0) sh_s_hi <= D;
    if (do_sh1) sh_s_lo <= D;
    if (do_sh2) sh_e_hi <= D;
    if (do_hi)  hi_byte <= D;
  end

  // Registered response stage: everything caused by an event appears one cycle later
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_q       <= 1'b1;
      sc         <= 16'd0;
      ec         <= EC_RST;
      sp         <= 16'd0;
      ep         <= EP_RST;
      cx         <= 16'd0;
      cy         <= 16'd0;
      disp_on    <= 1'b0;
      last_cmd   <= 8'd0;
      pix_valid  <= 1'b0;
      pix_x      <= 16'd0;
      pix_y      <= 16'd0;
      pix_color  <= 16'd0;
      frame_done <= 1'b0;
      stray_data <= 1'b0;
    end else begin
      wr_q       <= wr;
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      stray_data <= do_stray;
      if (cmd_ev) last_cmd <= D;
      if (do_swreset) begin
        sc      <= 16'd0;
        ec      <= EC_RST;
        sp      <= 16'd0;
        ep      <= EP_RST;
        cx      <= 16'd0;
        cy      <= 16'd0;
        disp_on <= 1'b0;
      end
      if (do_dispon)  disp_on <= 1'b1;
      if (do_dispoff) disp_on <= 1'b0;
      if (do_ramwr) begin
        cx <= sc;
        cy <= sp;
      end
      if (do_cas_commit) begin
        sc <= commit_s;
        ec <= commit_e;
      end
      if (do_pas_commit) begin
        sp <= commit_s;
        ep <= commit_e;
      end
      if (do_pix) begin
        pix_color <= {hi_byte, D};
        pix_x     <= cx;
        pix_y     <= cy;
        pix_valid <= (cx < H_LIM) && (cy < V_LIM);
        // Off-screen pixels still consume a cursor slot so the stream stays aligned.
        if (cx == ec && cy == ep) begin
          cx         <= sc;
          cy         <= sp;
          frame_done <= 1'b1;
        end else if (cx == ec) begin
          cx <= sc;
          cy <= cy + 16'd1;
        end else begin
          cx <= cx + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed bench for lcd_bus_receiver: a vector table of bus bytes with hand-computed responses,
// followed by hand sequences for held-high wr and reset asserted mid-command.
module tb_lcd_bus_receiver;

  logic        clk = 1'b0;
  logic        nrst;
  logic        wr;
  logic        dcx;
  logic [7:0]  D;
  logic        pix_valid;
  logic [15:0] pix_x, pix_y, pix_color;
  logic        frame_done, disp_on, stray_data;
  logic [7:0]  last_cmd;

  int errors = 0;
  int checks = 0;

  lcd_bus_receiver #(.H_RES(320), .V_RES(240)) dut (
    .clk(clk), .nrst(nrst), .wr(wr), .dcx(dcx), .D(D),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
    .frame_done(frame_done), .disp_on(disp_on), .last_cmd(last_cmd), .stray_data(stray_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dc;
    logic [7:0]  d;
    logic        pv;
    logic        chk_xy;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] c;
    logic        fd;
    logic        st;
    logic        on;
    logic [7:0]  lc;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] cur_lc = 8'h00;
  logic       cur_on = 1'b0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add_cmd(input logic [7:0] cmd, input logic on);
    cur_lc = cmd;
    cur_on = on;
    vecs.push_back('{1'b0, cmd, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, on, cmd});
  endtask

  task automatic add_dat(input logic [7:0] d, input logic st);
    vecs.push_back('{1'b1, d, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, st, cur_on, cur_lc});
  endtask

  task automatic add_pix(input logic [15:0] col, input logic pv, input logic [15:0] x,
                         input logic [15:0] y, input logic fd);
    add_dat(col[15:8], 1'b0);
    vecs.push_back('{1'b1, col[7:0], pv, 1'b1, x, y, col, fd, 1'b0, cur_on, cur_lc});
  endtask

  // Raises wr with the byte; returns one clock later with the response visible and wr still high.
  task automatic pulse_byte(input logic dc, input logic [7:0] d);
    @(negedge clk);
    dcx = dc;
    D   = d;
    wr  = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    nrst = 1'b0;
    wr   = 1'b1;
    dcx  = 1'b0;
    D    = 8'h00;

    // Byte table
    add_dat(8'h55, 1'b1);
    add_cmd(8'h2A, 1'b0);
    add_dat(8'h00, 1'b0); add_dat(8'h0A, 1'b0); add_dat(8'h00, 1'b0); add_dat(8'h0B, 1'b0);
    add_cmd(8'h2B, 1'b0);
    add_dat(8'h00, 1'b0); add_dat(8'h05, 1'b0); add_dat(8'h00, 1'b0); add_dat(8'h05, 1'b0);
    add_cmd(8'h2C, 1'b0);
    add_pix(16'hF800, 1'b1, 16'd10, 16'd5, 1'b0);
    add_pix(16'hF800, 1'b1, 16'd11, 16'd5, 1'b1);
    add_cmd(8'h2C, 1'b0);
    add_pix(16'h1234, 1'b1, 16'd10, 16'd5, 1'b0);
    add_pix(16'h5678, 1'b1, 16'd11, 16'd5, 1'b1);
    add_pix(16'h9ABC, 1'b1, 16'd10, 16'd5, 1'b0);
    add_pix(16'hDEF0, 1'b1, 16'd11, 16'd5, 1'b1);
    add_pix(16'h0F0F, 1'b1, 16'd10, 16'd5, 1'b0);
    add_cmd(8'h2C, 1'b0);
    add_dat(8'hF8, 1'b0);
    add_cmd(8'h29, 1'b1);
    add_dat(8'h77, 1'b1);
    add_cmd(8'h2C, 1'b1);
    add_pix(16'h1357, 1'b1, 16'd10, 16'd5, 1'b0);
    add_cmd(8'h28, 1'b0);
    add_cmd(8'h36, 1'b0);
    add_dat(8'h48, 1'b1);
    add_cmd(8'h2A, 1'b0);
    add_dat(8'h00, 1'b0); add_dat(8'h09, 1'b0); add_dat(8'h00, 1'b0); add_dat(8'h03, 1'b0);
    add_cmd(8'h2B, 1'b0);
    add_dat(8'h00, 1'b0); add_dat(8'h00, 1'b0); add_dat(8'h00, 1'b0); add_dat(8'h01, 1'b0);
    add_cmd(8'h2C, 1'b0);
    add_pix(16'h0001, 1'b1, 16'd9, 16'd0, 1'b0);
    add_pix(16'h0002, 1'b1, 16'd9, 16'd1, 1'b1);
    add_cmd(8'h2A, 1'b0);
    add_dat(8'h01, 1'b0); add_dat(8'h40, 1'b0); add_dat(8'h01, 1'b0); add_dat(8'h45, 1'b0);
    add_cmd(8'h2C, 1'b0);
    add_pix(16'hAAAA, 1'b0, 16'd320, 16'd0, 1'b0);
    add_pix(16'hBBBB, 1'b0, 16'd321, 16'd0, 1'b0);
    add_cmd(8'h2A, 1'b0);
    add_dat(8'h00, 1'b0); add_dat(8'h05, 1'b0);
    add_cmd(8'h2C, 1'b0);
    add_pix(16'hCCCC, 1'b0, 16'd320, 16'd0, 1'b0);
    add_cmd(8'h29, 1'b1);
    add_cmd(8'h2C, 1'b1);
    add_pix(16'h1111, 1'b0, 16'd320, 16'd0, 1'b0);
    add_dat(8'h22, 1'b0);
    add_cmd(8'h01, 1'b0);
    add_cmd(8'h2C, 1'b0);
    add_pix(16'h3333, 1'b1, 16'd0, 16'd0, 1'b0);
    add_pix(16'h4444, 1'b1, 16'd1, 16'd0, 1'b0);

    // Reset with wr high; release must not create an event
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst pix_valid", {15'd0, pix_valid}, 16'd0);
    chk("rst pix_x", pix_x, 16'd0);
    chk("rst pix_y", pix_y, 16'd0);
    chk("rst pix_color", pix_color, 16'd0);
    chk("rst frame_done", {15'd0, frame_done}, 16'd0);
    chk("rst stray_data", {15'd0, stray_data}, 16'd0);
    chk("rst disp_on", {15'd0, disp_on}, 16'd0);
    chk("rst last_cmd", {8'd0, last_cmd}, 16'd0);
    wr = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      pulse_byte(vecs[i].dc, vecs[i].d);
      chk($sformatf("v%0d pix_valid", i), {15'd0, pix_valid}, {15'd0, vecs[i].pv});
      chk($sformatf("v%0d frame_done", i), {15'd0, frame_done}, {15'd0, vecs[i].fd});
      chk($sformatf("v%0d stray_data", i), {15'd0, stray_data}, {15'd0, vecs[i].st});
      chk($sformatf("v%0d disp_on", i), {15'd0, disp_on}, {15'd0, vecs[i].on});
      chk($sformatf("v%0d last_cmd", i), {8'd0, last_cmd}, {8'd0, vecs[i].lc});
      if (vecs[i].chk_xy) begin
        chk($sformatf("v%0d pix_x", i), pix_x, vecs[i].x);
        chk($sformatf("v%0d pix_y", i), pix_y, vecs[i].y);
        chk($sformatf("v%0d pix_color", i), pix_color, vecs[i].c);
      end
      wr = 1'b0;
    end

    // wr held high across several clocks and a bus change yields a single event
    pulse_byte(1'b0, 8'h29);
    repeat (4) @(negedge clk);
    D = 8'h2A;
    repeat (3) @(negedge clk);
    chk("held last_cmd", {8'd0, last_cmd}, 16'h0029);
    chk("held disp_on", {15'd0, disp_on}, 16'd1);
    wr = 1'b0;
    pulse_byte(1'b1, 8'h11);
    chk("held stray", {15'd0, stray_data}, 16'd1);
    wr = 1'b0;

    // Commit a 3..4 column window, start another CASET, then reset mid-command
    pulse_byte(1'b0, 8'h2A); wr = 1'b0;
    pulse_byte(1'b1, 8'h00); wr = 1'b0;
    pulse_byte(1'b1, 8'h03); wr = 1'b0;
    pulse_byte(1'b1, 8'h00); wr = 1'b0;
    pulse_byte(1'b1, 8'h04); wr = 1'b0;
    pulse_byte(1'b0, 8'h2A); wr = 1'b0;
    pulse_byte(1'b1, 8'h00); wr = 1'b0;
    @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    chk("async last_cmd", {8'd0, last_cmd}, 16'd0);
    chk("async disp_on", {15'd0, disp_on}, 16'd0);
    chk("async pix_x", pix_x, 16'd0);
    repeat (2) @(negedge clk);
    chk("async pix_valid", {15'd0, pix_valid}, 16'd0);
    nrst = 1'b1;
    pulse_byte(1'b0, 8'h2C); wr = 1'b0;
    chk("post-rst last_cmd", {8'd0, last_cmd}, 16'h002C);
    pulse_byte(1'b1, 8'h00); wr = 1'b0;
    pulse_byte(1'b1, 8'hFF);
    chk("post-rst pix_valid", {15'd0, pix_valid}, 16'd1);
    chk("post-rst pix_x", pix_x, 16'd0);
    chk("post-rst pix_y", pix_y, 16'd0);
    chk("post-rst pix_color", pix_color, 16'h00FF);
    wr = 1'b0;
    @(negedge clk);
    chk("pulse width", {15'd0, pix_valid}, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
